// File: rtl/cart_mem_pkg.sv
// rtl/cart_mem_pkg.sv - shared types and constants for the cartridge RAM bridge
package cart_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FILL  = 2'd3
    } state_e;

    localparam logic [1:0] BE_NONE    = 2'b00;
    localparam logic [1:0] BE_LO      = 2'b01;
    localparam logic [1:0] BE_HI      = 2'b10;
    localparam logic [1:0] BE_ALL     = 2'b11;
    localparam logic [7:0] RESET_DOUT = 8'hFF;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cart_line_buf.sv
// rtl/cart_line_buf.sv - one-word read line buffer with tag compare and byte patch
module cart_line_buf
    import cart_mem_pkg::*;
#(
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [15:0]      data_o,
    input  logic             fill_en_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [15:0]      fill_data_i,
    input  logic             patch_en_i,
    input  logic [TAG_W-1:0] patch_tag_i,
    input  logic             patch_hi_i,
    input  logic [7:0]       patch_byte_i
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end else if (patch_en_i && valid_q && (patch_tag_i == tag_q)) begin
            // Write-through keeps the line coherent instead of invalidating it
            if (patch_hi_i) data_d[15:8] = patch_byte_i;
            else            data_d[7:0]  = patch_byte_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/cart_mem_bridge.sv
// rtl/cart_mem_bridge.sv - byte-wide cartridge RAM port to 16-bit req/ack memory bridge
module cart_mem_bridge
    import cart_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 25,
    parameter int MEM_AW     = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [7:0]            ram_din,
    input  logic                  ram_we,
    input  logic                  ram_rd,
    output logic [7:0]            ram_dout,
    output logic                  ram_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [15:0]           mem_wdata,
    output logic [1:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    output logic                  wr_overrun
);

    state_e                state_q, state_d;
    logic                  latch_full_q, latch_full_d;
    logic [ADDR_WIDTH-1:0] latch_addr_q, latch_addr_d;
    logic [7:0]            latch_din_q, latch_din_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            dout_q, dout_d;
    logic [MEM_AW-1:0]     maddr_q, maddr_d;
    logic [15:0]           mwdata_q, mwdata_d;
    logic [1:0]            mbe_q, mbe_d;

    logic        hit;
    logic [15:0] line_data;
    logic        fill_en, patch_en;

    assign fill_en  = (state_q == ST_READ)  && mem_ack;
    assign patch_en = (state_q == ST_WRITE) && mem_ack;

    cart_line_buf #(.TAG_W(MEM_AW)) u_line (
        .clk          (clk),
        .rst          (reset),
        .lookup_tag_i (ram_addr[ADDR_WIDTH-1:1]),
        .hit_o        (hit),
        .data_o       (line_data),
        .fill_en_i    (fill_en),
        .fill_tag_i   (maddr_q),
        .fill_data_i  (mem_rdata),
        .patch_en_i   (patch_en),
        .patch_tag_i  (latch_addr_q[ADDR_WIDTH-1:1]),
        .patch_hi_i   (latch_addr_q[0]),
        .patch_byte_i (latch_din_q)
    );

    always_comb begin
        state_d      = state_q;
        latch_full_d = latch_full_q;
        latch_addr_d = latch_addr_q;
        latch_din_d  = latch_din_q;
        overrun_d    = overrun_q;
        dout_d       = dout_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        mbe_d        = mbe_q;

        case (state_q)
            ST_IDLE: begin
                if (latch_full_q) begin
                    state_d  = ST_WRITE;
                    maddr_d  = latch_addr_q[ADDR_WIDTH-1:1];
                    mwdata_d = {latch_din_q, latch_din_q};
                    mbe_d    = latch_addr_q[0] ? BE_HI : BE_LO;
                end else if (ram_rd && !hit) begin
                    state_d = ST_READ;
                    maddr_d = ram_addr[ADDR_WIDTH-1:1];
                    mbe_d   = BE_ALL;
                end
                if (ram_rd && hit) dout_d = sel_byte(line_data, ram_addr[0]);
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d      = ST_IDLE;
                    latch_full_d = 1'b0;
                end
            end
            ST_READ: begin
                if (mem_ack) state_d = ST_FILL;
            end
            ST_FILL: begin
                state_d = ST_IDLE;
                if (hit) dout_d = sel_byte(line_data, ram_addr[0]);
            end
            default: state_d = ST_IDLE;
        endcase

        // A pulse against a full latch (even one draining this cycle) is lost
        if (ram_we) begin
            if (latch_full_q) begin
                overrun_d = 1'b1;
            end else begin
                latch_full_d = 1'b1;
                latch_addr_d = ram_addr;
                latch_din_d  = ram_din;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            latch_full_q <= 1'b0;
            latch_addr_q <= '0;
            latch_din_q  <= '0;
            overrun_q    <= 1'b0;
            dout_q       <= RESET_DOUT;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            mbe_q        <= BE_NONE;
        end else begin
            state_q      <= state_d;
            latch_full_q <= latch_full_d;
            latch_addr_q <= latch_addr_d;
            latch_din_q  <= latch_din_d;
            overrun_q    <= overrun_d;
            dout_q       <= dout_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            mbe_q        <= mbe_d;
        end
    end

    assign mem_req    = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
    assign mem_be     = mbe_q;
    assign ram_dout   = dout_q;
    assign wr_overrun = overrun_q;
    assign ram_ready  = (state_q == ST_IDLE) && !latch_full_q && (!ram_rd || hit);

endmodule

// File: tb/tb_cart_mem_bridge.sv
// tb/tb_cart_mem_bridge.sv - directed self-checking bench for cart_mem_bridge
module tb_cart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_rd;
    logic [7:0]  ram_dout;
    logic        ram_ready;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wr_overrun;

    int n_err = 0;
    int n_chk = 0;

    cart_mem_bridge #(.ADDR_WIDTH(25), .MEM_AW(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_rd     (ram_rd),
        .ram_dout   (ram_dout),
        .ram_ready  (ram_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wr_overrun (wr_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;
        ram_rd    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_be", 32'(mem_be), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_dout", 32'(ram_dout), 32'hFF);
        check("rst_ready", 32'(ram_ready), 32'h1);
        check("rst_ovr", 32'(wr_overrun), 32'h0);
        reset = 1'b0;

        // Cold read miss at 0x00010
        ram_addr = 25'h00010;
        ram_rd   = 1'b1;
        #1;
        check("miss_ready", 32'(ram_ready), 32'h0);
        check("miss_noreq_yet", 32'(mem_req), 32'h0);
        tick();
        check("rd_req", 32'(mem_req), 32'h1);
        check("rd_we", 32'(mem_we), 32'h0);
        check("rd_addr", 32'(mem_addr), 32'h000008);
        check("rd_be", 32'(mem_be), 32'h3);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBBAA;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        check("fill_req", 32'(mem_req), 32'h0);
        check("fill_ready", 32'(ram_ready), 32'h0);
        tick();
        check("rd_dout", 32'(ram_dout), 32'hAA);
        check("rd_ready", 32'(ram_ready), 32'h1);

        // Same-word hit on the upper byte
        ram_addr = 25'h00011;
        #1;
        check("hit_ready", 32'(ram_ready), 32'h1);
        tick();
        check("hit_noreq", 32'(mem_req), 32'h0);
        check("hit_dout", 32'(ram_dout), 32'hBB);

        // Lower-byte write at 0x00020
        ram_rd   = 1'b0;
        ram_addr = 25'h00020;
        ram_din  = 8'h5A;
        ram_we   = 1'b1;
        tick();
        ram_we = 1'b0;
        check("wr_latched_ready", 32'(ram_ready), 32'h0);
        tick();
        check("wr_req", 32'(mem_req), 32'h1);
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'h000010);
        check("wr_be", 32'(mem_be), 32'h1);
        check("wr_wdata", 32'(mem_wdata), 32'h5A5A);
        tick();
        check("wr_wait_ready", 32'(ram_ready), 32'h0);
        mem_ack = 1'b1;
        #1;
        check("wr_ack_ready", 32'(ram_ready), 32'h0);
        tick();
        mem_ack = 1'b0;
        check("wr_done_ready", 32'(ram_ready), 32'h1);
        check("wr_done_req", 32'(mem_req), 32'h0);

        // Upper-byte write into the cached word patches the line
        ram_addr = 25'h00011;
        ram_din  = 8'h77;
        ram_we   = 1'b1;
        tick();
        ram_we = 1'b0;
        tick();
        check("patch_be", 32'(mem_be), 32'h2);
        check("patch_addr", 32'(mem_addr), 32'h000008);
        check("patch_wdata", 32'(mem_wdata), 32'h7777);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ram_rd  = 1'b1;
        #1;
        check("patch_hit_ready", 32'(ram_ready), 32'h1);
        tick();
        check("patch_dout", 32'(ram_dout), 32'h77);
        check("patch_noreq", 32'(mem_req), 32'h0);
        ram_addr = 25'h00010;
        tick();
        check("patch_lo_kept", 32'(ram_dout), 32'hAA);

        // Writes during a slow read; second write overruns the latch
        ram_addr = 25'h00040;
        tick();
        check("slow_req", 32'(mem_req), 32'h1);
        check("slow_addr", 32'(mem_addr), 32'h000020);
        ram_addr = 25'h00041;
        ram_din  = 8'h33;
        ram_we   = 1'b1;
        tick();
        ram_addr = 25'h00050;
        ram_din  = 8'h99;
        tick();
        ram_we   = 1'b0;
        ram_addr = 25'h00040;
        check("ovr_set", 32'(wr_overrun), 32'h1);
        check("slow_still_read", 32'(mem_we), 32'h0);
        check("slow_addr_held", 32'(mem_addr), 32'h000020);
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hD0C0;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        tick();
        check("slow_dout", 32'(ram_dout), 32'hC0);
        check("slow_ready_latch", 32'(ram_ready), 32'h0);
        tick();
        check("queued_wr_we", 32'(mem_we), 32'h1);
        check("queued_wr_addr", 32'(mem_addr), 32'h000020);
        check("queued_wr_be", 32'(mem_be), 32'h2);
        check("queued_wr_wdata", 32'(mem_wdata), 32'h3333);
        mem_ack = 1'b1;
        tick();
        mem_ack  = 1'b0;
        ram_addr = 25'h00041;
        tick();
        check("queued_patch_dout", 32'(ram_dout), 32'h33);
        check("ovr_sticky", 32'(wr_overrun), 32'h1);

        // Reset in the middle of a read
        ram_addr = 25'h00080;
        tick();
        check("pre_rst_req", 32'(mem_req), 32'h1);
        #2;
        reset  = 1'b1;
        ram_rd = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_dout", 32'(ram_dout), 32'hFF);
        check("mid_rst_ready", 32'(ram_ready), 32'h1);
        check("mid_rst_ovr", 32'(wr_overrun), 32'h0);
        tick();
        reset    = 1'b0;
        ram_rd   = 1'b1;
        ram_addr = 25'h00040;
        #1;
        check("post_rst_miss", 32'(ram_ready), 32'h0);
        tick();
        check("post_rst_req", 32'(mem_req), 32'h1);
        check("post_rst_addr", 32'(mem_addr), 32'h000020);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cart_mem_bridge.md
Name: cart_mem_bridge

Overview:
- Responder for the cartridge mapper's byte-wide RAM port (ram_addr/ram_din/ram_we/ram_rd → ram_dout/ram_ready).
- Converts it to a 16-bit word request/acknowledge memory interface (SDRAM/PSRAM controller side).
- Holds a one-word read line buffer so repeated CPU fetches from the same word cost no memory access.
- Serialises ROM-download byte writes and back-pressures the loader through ram_ready.

Parameters:
- ADDR_WIDTH, 25, byte address width on cart side
- MEM_AW, 24, word address width on memory side (= ADDR_WIDTH-1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ram_addr  in  ADDR_WIDTH  byte address from mapper
- ram_din  in  8  write byte
- ram_we  in  1  one-cycle write strobe, one byte per pulse
- ram_rd  in  1  read enable, level
- ram_dout  out  8  read byte, registered
- ram_ready  out  1  high = bridge can accept a write and ram_dout is valid for current ram_addr
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  MEM_AW  word address = ram_addr[ADDR_WIDTH-1:1]
- mem_wdata  out  16  ram_din replicated on both bytes
- mem_be  out  2  byte enables: addr[0]=0 → 01, addr[0]=1 → 10; 11 on reads
- mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle on reads
- mem_rdata  in  16  read word
- wr_overrun  out  1  sticky: ram_we seen while write latch already full

Behaviour:
- Reset (async): state IDLE, mem_req=0, mem_we=0, mem_be=00, mem_addr=0, mem_wdata=0, ram_dout=8'hFF, ram_ready=1, line buffer invalid, write latch empty, wr_overrun=0.
- Write latch: 1 entry (addr, byte). A ram_we pulse loads it in any state; ram_ready drops the next cycle. If already full, the pulse is dropped and wr_overrun set (cleared only by reset).
- States: IDLE, WRITE, READ, FILL.
- IDLE priority: (1) latch full → WRITE; (2) ram_rd=1 and line miss → READ; (3) else stay.
- Line hit: valid and tag == ram_addr[ADDR_WIDTH-1:1]. In IDLE, on hit with ram_rd=1, ram_dout <= selected byte (addr[0]=1 → upper) every cycle, ram_ready=1; latency 1 cycle from address change.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_be/mem_wdata from latch. On mem_ack: latch emptied, mem_req=0. If latch word == line tag, patch that byte of the line buffer (stays valid). → IDLE.
- READ: mem_req=1, mem_we=0, mem_addr captured at entry (held stable even if ram_addr moves). On mem_ack: line <= mem_rdata, tag <= captured address, valid=1 → FILL.
- FILL: one cycle; ram_dout updated from line for the current ram_addr if it hits, otherwise miss re-evaluated in IDLE → IDLE.
- Miss latency: mem_req rises 1 cycle after miss detected; ram_dout valid 2 cycles after mem_ack.
- ram_ready = (state==IDLE) & latch empty & (ram_rd=0 | hit). Combinational from registered state/latch/tag.
- ram_we in the same cycle a read mem_ack arrives: both accepted; fill completes, write served next.
- ram_rd falling during READ: request completes normally (no abort); line filled.
- Address wrap: none; MEM_AW addresses pass through unmodified.
- mem_ack in IDLE/FILL (spurious): ignored.

Decomposition:
- Package cart_mem_pkg: state enum (IDLE, WRITE, READ, FILL), byte-enable constants BE_LO=2'b01, BE_HI=2'b10, BE_ALL=2'b11, RESET_DOUT=8'hFF.
- Sub-module cart_line_buf: tag, valid, 16-bit data; ports for hit compare, fill, byte patch, invalidate-on-reset.

Test Plan:
- Reset then ram_rd=1, ram_addr=0x00010 → one read req mem_addr=0x000008, be=11; ack with rdata=0xBBAA → ram_dout=0xAA, ram_ready=1 two cycles later.
- After that, ram_addr=0x00011 → no mem_req; ram_dout=0xBB next cycle.
- ram_we pulses at 0x00020 din=0x5A → mem_we=1, addr=0x000010, be=01, wdata=0x5A5A; ram_ready low until 1 cycle after ack.
- Write 0x00011 din=0x77 while line holds 0x00010 word → after ack, read 0x00011 hits with ram_dout=0x77, no read req.
- ram_we during outstanding read (ack delayed 5 cycles) → read completes first, then write issued; second ram_we before latch drains → dropped, wr_overrun=1.
- Assert reset mid-READ with mem_req=1 → mem_req=0, ram_dout=0xFF, ram_ready=1, line invalid immediately.
